// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Word width, address-alignment mask, port indices and the access-legality helper.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;

    // Low address bits that must be zero for a word access
    localparam logic [WORD_W-1:0] ADDR_ALIGN_MASK = 32'h0000_0003;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_e;

    // Word-aligned and inside the memory's word range
    function automatic logic addr_legal(input logic [WORD_W-1:0] addr,
                                        input int unsigned       depth);
        return ((addr & ADDR_ALIGN_MASK) == '0) &&
               ({2'b00, addr[WORD_W-1:2]} < depth);
    endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// Two-way priority selector with port-1 starvation counter.
// Port 0 wins ties unless port 1 has waited MAX_WAIT cycles or holds a lock.
// hold0 forces one cycle for port 0 after a lock expires.
module dmem_arb_prio
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  req0,
    input  logic  req1,
    input  logic  force1,
    input  logic  hold0,
    output logic  gnt0,
    output logic  gnt1,
    output port_e sel
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic [3:0] wait_nxt;
    logic       starved;

    // Grant selection and next wait count
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        starved  = (wait_cnt == WAIT_LIM);
        if (req0 && req1) begin
            if ((starved || force1) && !hold0) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
        sel = gnt1 ? PORT_DMA : PORT_CPU;

        wait_nxt = '0;
        if (req1 && !gnt1) begin
            wait_nxt = starved ? wait_cnt : wait_cnt + 4'd1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_nxt;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: port 0 = MEM stage, port 1 = loader/DMA.
// Drives the memory from the granted port and returns registered read data.
// Optional burst lock for port 1 enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [WORD_W-1:0] addr0,
    input  logic [WORD_W-1:0] addr1,
    input  logic [WORD_W-1:0] wdata0,
    input  logic [WORD_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              stall0,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [WORD_W-1:0] rdata0,
    output logic [WORD_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [WORD_W-1:0] MemAddr,
    output logic [WORD_W-1:0] MemWriteData,
    input  logic [WORD_W-1:0] MemReadData
);

    port_e             sel;
    logic              force1;
    logic              hold0;
    logic              granted;
    logic              sel_we;
    logic              sel_legal;
    logic [WORD_W-1:0] sel_addr;
    logic [WORD_W-1:0] sel_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [WORD_W-1:0] rsp_data;

    dmem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .req1   (req1),
        .force1 (force1),
        .hold0  (hold0),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .sel    (sel)
    );

`ifdef DMEM_ARB_LOCK_EN
    localparam int unsigned LCW = $clog2(LOCK_MAX + 1);

    logic           lock_q;
    logic           hold0_q;
    logic [LCW-1:0] lock_cnt;
    logic [LCW-1:0] lock_cnt_nxt;

    assign force1 = lock_q & req1 & lock1;
    assign hold0  = hold0_q;

    // Count of consecutive locked grants including this one
    always_comb begin
        lock_cnt_nxt = (lock_q ? lock_cnt : '0) + LCW'(1);
    end

    // Lock tracking; reaching LOCK_MAX releases and reserves one cycle for port 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q   <= 1'b0;
            lock_cnt <= '0;
            hold0_q  <= 1'b0;
        end else if (gnt1 && lock1) begin
            if (lock_cnt_nxt == LCW'(LOCK_MAX)) begin
                lock_q   <= 1'b0;
                lock_cnt <= '0;
                hold0_q  <= 1'b1;
            end else begin
                lock_q   <= 1'b1;
                lock_cnt <= lock_cnt_nxt;
                hold0_q  <= 1'b0;
            end
        end else begin
            lock_q   <= 1'b0;
            lock_cnt <= '0;
            hold0_q  <= 1'b0;
        end
    end
`else
    localparam int unsigned lock_max_unused = LOCK_MAX;
    logic lock1_unused;

    assign lock1_unused = lock1;
    assign force1       = 1'b0;
    assign hold0        = 1'b0;
`endif

    // Granted-port mux, legality and memory control
    always_comb begin
        granted   = gnt0 | gnt1;
        sel_we    = (sel == PORT_DMA) ? we1    : we0;
        sel_addr  = (sel == PORT_DMA) ? addr1  : addr0;
        sel_wdata = (sel == PORT_DMA) ? wdata1 : wdata0;
        sel_legal = addr_legal(sel_addr, DEPTH);

        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemAddr      = '0;
        MemWriteData = '0;
        if (rst_n && granted) begin
            MemAddr      = sel_addr;
            MemWriteData = sel_wdata;
            MemRead      = sel_legal & ~sel_we;
            MemWrite     = sel_legal &  sel_we;
        end

        stall0    = req0 & ~gnt0;
        rsp_valid = granted & (~sel_legal | ~sel_we);
        rsp_err   = granted & ~sel_legal;
        rsp_data  = sel_legal ? MemReadData : '0;
    end

    // Registered response to the winning port; rdata holds between responses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= rsp_valid & gnt0;
            rvalid1 <= rsp_valid & gnt1;
            err0    <= rsp_err & gnt0;
            err1    <= rsp_err & gnt1;
            if (rsp_valid && gnt0) begin
                rdata0 <= rsp_data;
            end
            if (rsp_valid && gnt1) begin
                rdata1 <= rsp_data;
            end
        end
    end

endmodule
